// File: rtl/cpu_pkg.sv
// Shared opcode/funct constants, FSM state and ALU-op types for the
// multi-cycle core, plus the instruction decode helpers.
package cpu_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_HALT  = 6'h3F;

   localparam logic [5:0] FN_SLL   = 6'h00;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_SLT   = 6'h2A;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5
   } state_e;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_SLT,
      ALU_SLL,
      ALU_NONE
   } alu_op_e;

   typedef enum logic [3:0] {
      IC_ALU_R,
      IC_ADDI,
      IC_ORI,
      IC_LW,
      IC_SW,
      IC_BEQ,
      IC_BNE,
      IC_J,
      IC_HALT,
      IC_NOP
   } iclass_e;

   function automatic alu_op_e decode_alu(input logic [5:0] op,
                                          input logic [5:0] fn);
      alu_op_e a;
      a = ALU_NONE;
      case (op)
         OP_RTYPE: begin
            case (fn)
               FN_ADD:  a = ALU_ADD;
               FN_SUB:  a = ALU_SUB;
               FN_AND:  a = ALU_AND;
               FN_OR:   a = ALU_OR;
               FN_SLT:  a = ALU_SLT;
               FN_SLL:  a = ALU_SLL;
               default: a = ALU_NONE;
            endcase
         end
         OP_ADDI, OP_LW, OP_SW: a = ALU_ADD;
         OP_ORI:  a = ALU_OR;
         default: a = ALU_NONE;
      endcase
      return a;
   endfunction

   // Unsupported R-type functs fall into IC_NOP with unknown opcodes
   function automatic iclass_e decode_class(input logic [5:0] op,
                                            input logic [5:0] fn);
      iclass_e c;
      c = IC_NOP;
      case (op)
         OP_RTYPE: c = (decode_alu(op, fn) != ALU_NONE) ? IC_ALU_R : IC_NOP;
         OP_ADDI:  c = IC_ADDI;
         OP_ORI:   c = IC_ORI;
         OP_LW:    c = IC_LW;
         OP_SW:    c = IC_SW;
         OP_BEQ:   c = IC_BEQ;
         OP_BNE:   c = IC_BNE;
         OP_J:     c = IC_J;
         OP_HALT:  c = IC_HALT;
         default:  c = IC_NOP;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/cpu_regfile.sv
// Two-read, one-write register file; register 0 is hardwired to zero
// and the whole array clears on synchronous reset.
module cpu_regfile
   import cpu_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [$clog2(NREGS)-1:0] ra_a,
   input  logic [$clog2(NREGS)-1:0] ra_b,
   output logic [XLEN-1:0]          rd_a,
   output logic [XLEN-1:0]          rd_b,
   input  logic                     we,
   input  logic [$clog2(NREGS)-1:0] wa,
   input  logic [XLEN-1:0]          wd
);

   logic [XLEN-1:0] regs_q [NREGS];
   logic [XLEN-1:0] regs_d [NREGS];

   always_comb begin
      regs_d = regs_q;
      if (we && (wa != '0)) begin
         regs_d[wa] = wd;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         regs_q <= '{default: '0};
      end else begin
         regs_q <= regs_d;
      end
   end

   assign rd_a = (ra_a == '0) ? '0 : regs_q[ra_a];
   assign rd_b = (ra_b == '0) ? '0 : regs_q[ra_b];

endmodule

// File: rtl/multi_cycle_cpu.sv
// Multi-cycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB FSM driving
// split req/ack instruction and data memory ports.
module multi_cycle_cpu
   import cpu_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter int              NREGS    = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            Reset,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   input  logic            dmem_ack,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic [XLEN-1:0] curPC,
   output logic [2:0]      state,
   output logic            halted
);

   localparam int AW = $clog2(NREGS);

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [31:0]     ir_q, ir_d;
   logic [XLEN-1:0] a_q, a_d;
   logic [XLEN-1:0] b_q, b_d;
   logic [XLEN-1:0] imm_q, imm_d;
   logic [XLEN-1:0] alu_q, alu_d;
   logic [XLEN-1:0] mdr_q, mdr_d;

   iclass_e         ic;
   alu_op_e         aop;
   logic [XLEN-1:0] alu_b;
   logic [XLEN-1:0] alu_res;
   logic [XLEN-1:0] pc_plus4;
   logic [XLEN-1:0] br_target;
   logic [XLEN-1:0] j_target;
   logic            ireq_c;
   logic            dreq_c;
   logic            rf_we;
   logic [AW-1:0]   rf_wa;
   logic [XLEN-1:0] rf_wd;
   logic [XLEN-1:0] rf_a;
   logic [XLEN-1:0] rf_b;

   assign ic  = decode_class(ir_q[31:26], ir_q[5:0]);
   assign aop = decode_alu(ir_q[31:26], ir_q[5:0]);

   assign pc_plus4  = pc_q + XLEN'(4);
   assign br_target = pc_plus4 + {imm_q[XLEN-3:0], 2'b00};
   assign j_target  = {pc_plus4[XLEN-1:28], ir_q[25:0], 2'b00};

   always_comb begin
      alu_b   = (ic == IC_ALU_R) ? b_q : imm_q;
      alu_res = '0;
      unique case (aop)
         ALU_ADD: alu_res = a_q + alu_b;
         ALU_SUB: alu_res = a_q - alu_b;
         ALU_AND: alu_res = a_q & alu_b;
         ALU_OR:  alu_res = a_q | alu_b;
         ALU_SLT: alu_res = ($signed(a_q) < $signed(alu_b)) ?
                            XLEN'(1) : '0;
         ALU_SLL: alu_res = alu_b << ir_q[10:6];
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      a_d     = a_q;
      b_d     = b_q;
      imm_d   = imm_q;
      alu_d   = alu_q;
      mdr_d   = mdr_q;
      ireq_c  = 1'b0;
      dreq_c  = 1'b0;
      rf_we   = 1'b0;
      unique case (state_q)
         ST_FETCH: begin
            ireq_c = 1'b1;
            if (imem_ack) begin
               ir_d    = imem_rdata;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            a_d     = rf_a;
            b_d     = rf_b;
            imm_d   = (ic == IC_ORI) ?
                      {{(XLEN-16){1'b0}}, ir_q[15:0]} :
                      {{(XLEN-16){ir_q[15]}}, ir_q[15:0]};
            state_d = (ic == IC_HALT) ? ST_HALT : ST_EXEC;
         end
         ST_EXEC: begin
            alu_d = alu_res;
            unique case (ic)
               IC_ALU_R, IC_ADDI, IC_ORI: state_d = ST_WB;
               IC_LW, IC_SW:              state_d = ST_MEM;
               IC_BEQ: begin
                  pc_d    = (a_q == b_q) ? br_target : pc_plus4;
                  state_d = ST_FETCH;
               end
               IC_BNE: begin
                  pc_d    = (a_q != b_q) ? br_target : pc_plus4;
                  state_d = ST_FETCH;
               end
               IC_J: begin
                  pc_d    = j_target;
                  state_d = ST_FETCH;
               end
               default: begin
                  pc_d    = pc_plus4;
                  state_d = ST_FETCH;
               end
            endcase
         end
         ST_MEM: begin
            dreq_c = 1'b1;
            if (dmem_ack) begin
               if (ic == IC_SW) begin
                  pc_d    = pc_plus4;
                  state_d = ST_FETCH;
               end else begin
                  mdr_d   = dmem_rdata;
                  state_d = ST_WB;
               end
            end
         end
         ST_WB: begin
            rf_we   = 1'b1;
            pc_d    = pc_plus4;
            state_d = ST_FETCH;
         end
         default: state_d = ST_HALT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         state_q <= ST_FETCH;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         imm_q   <= '0;
         alu_q   <= '0;
         mdr_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         a_q     <= a_d;
         b_q     <= b_d;
         imm_q   <= imm_d;
         alu_q   <= alu_d;
         mdr_q   <= mdr_d;
      end
   end

   // R-type writes rd, immediate forms and loads write rt
   assign rf_wa = (ic == IC_ALU_R) ? ir_q[11 +: AW] : ir_q[16 +: AW];
   assign rf_wd = (ic == IC_LW) ? mdr_q : alu_q;

   cpu_regfile #(
      .XLEN  (XLEN),
      .NREGS (NREGS)
   ) u_regfile (
      .clk  (clk),
      .rst  (Reset),
      .ra_a (ir_q[21 +: AW]),
      .ra_b (ir_q[16 +: AW]),
      .rd_a (rf_a),
      .rd_b (rf_b),
      .we   (rf_we),
      .wa   (rf_wa),
      .wd   (rf_wd)
   );

   assign imem_req   = ireq_c & ~Reset;
   assign imem_addr  = pc_q;
   assign dmem_req   = dreq_c & ~Reset;
   assign dmem_we    = (ic == IC_SW);
   assign dmem_addr  = alu_q;
   assign dmem_wdata = b_q;
   assign curPC      = pc_q;
   assign state      = state_q;
   assign halted     = (state_q == ST_HALT);

endmodule

// File: tb/tb_multi_cycle_cpu.sv
// Directed bench: small hand-assembled programs on a 32-bit core and a
// 64-bit/8-register core, checked with immediate assertions.
module tb_multi_cycle_cpu;

   localparam logic [31:0] HALT_I = 32'hFC00_0000;
   localparam logic [31:0] UNK_OP = 32'hF8A5_1234;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst32 = 1'b1;
   logic        ireq, iack, dreq, dwe, dack, halt32;
   logic [31:0] iaddr, irdata, daddr, dwdata, drdata, pc32;
   logic [2:0]  st32;
   logic [31:0] imem [64];
   logic [31:0] dmem [16];
   logic        inoise = 1'b0;
   logic        dnoise = 1'b0;
   int          ddelay = 0;
   int          dcnt = 0;

   logic        rst64 = 1'b1;
   logic        ireq64, iack64, dreq64, dwe64, dack64, halt64;
   logic [63:0] iaddr64, daddr64, dwdata64, drdata64, pc64;
   logic [31:0] irdata64;
   logic [2:0]  st64;
   logic [31:0] imem64 [16];

   assign irdata   = imem[iaddr[7:2]];
   assign drdata   = dmem[daddr[5:2]];
   assign iack     = ireq | inoise;
   assign dack     = (dreq && (dcnt == ddelay)) | dnoise;
   assign irdata64 = imem64[iaddr64[5:2]];
   assign drdata64 = 64'hF000_0000_0000_0001;
   assign iack64   = ireq64;
   assign dack64   = dreq64;

   multi_cycle_cpu dut32 (
      .clk        (clk),
      .Reset      (rst32),
      .imem_req   (ireq),
      .imem_addr  (iaddr),
      .imem_ack   (iack),
      .imem_rdata (irdata),
      .dmem_req   (dreq),
      .dmem_we    (dwe),
      .dmem_addr  (daddr),
      .dmem_wdata (dwdata),
      .dmem_ack   (dack),
      .dmem_rdata (drdata),
      .curPC      (pc32),
      .state      (st32),
      .halted     (halt32)
   );

   multi_cycle_cpu #(.XLEN(64), .NREGS(8)) dut64 (
      .clk        (clk),
      .Reset      (rst64),
      .imem_req   (ireq64),
      .imem_addr  (iaddr64),
      .imem_ack   (iack64),
      .imem_rdata (irdata64),
      .dmem_req   (dreq64),
      .dmem_we    (dwe64),
      .dmem_addr  (daddr64),
      .dmem_wdata (dwdata64),
      .dmem_ack   (dack64),
      .dmem_rdata (drdata64),
      .curPC      (pc64),
      .state      (st64),
      .halted     (halt64)
   );

   int          n_assert = 0;
   int          n_fail = 0;
   logic [31:0] flog [32];
   int          nf = 0;
   int          dlen [8];
   int          ntx = 0;
   int          dreq_cyc = 0;
   logic [31:0] st_addr = '0;
   logic [31:0] st_data = '0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: observe at negedge, advance to 1ns after posedge
   task automatic tick();
      int dn;
      @(negedge clk);
      if (ireq && iack && nf < 32) begin
         flog[nf] = iaddr;
         nf++;
      end
      dn = 0;
      if (dreq) dreq_cyc++;
      if (dreq && dack) begin
         if (dwe) begin
            st_addr = daddr;
            st_data = dwdata;
            dmem[daddr[5:2]] = dwdata;
         end
         if (ntx < 8) dlen[ntx] = dreq_cyc;
         ntx++;
         dreq_cyc = 0;
      end else if (dreq) begin
         dn = dcnt + 1;
      end else begin
         dreq_cyc = 0;
      end
      @(posedge clk);
      #1;
      dcnt = dn;
   endtask

   task automatic restart();
      rst32 = 1'b1;
      tick();
      rst32 = 1'b0;
      nf = 0;
      ntx = 0;
      dreq_cyc = 0;
   endtask

   task automatic clear_imem();
      for (int i = 0; i < 64; i++) imem[i] = HALT_I;
      for (int i = 0; i < 16; i++) dmem[i] = '0;
   endtask

   initial begin
      clear_imem();
      for (int i = 0; i < 16; i++) imem64[i] = HALT_I;
      imem[0] = 32'h2001_0005;
      imem[1] = 32'h2002_FFFD;
      imem[2] = 32'h0022_1820;
      imem[3] = HALT_I;

      tick();
      chk("rst_state", st32, 3'd0);
      chk("rst_pc", pc32, 32'h0);
      chk("rst_halted", halt32, 1'b0);
      chk("rst_imem_req", ireq, 1'b0);
      chk("rst_dmem_req", dreq, 1'b0);
      rst32 = 1'b0;
      nf = 0;

      repeat (13) tick();
      chk("prog1_not_halted_13", halt32, 1'b0);
      tick();
      chk("prog1_halted_14", halt32, 1'b1);
      chk("prog1_state", st32, 3'd5);
      chk("prog1_pc", pc32, 32'hC);
      chk("prog1_r1", dut32.u_regfile.regs_q[1], 32'h5);
      chk("prog1_r2", dut32.u_regfile.regs_q[2], 32'hFFFF_FFFD);
      chk("prog1_r3", dut32.u_regfile.regs_q[3], 32'h2);
      repeat (3) tick();
      chk("prog1_held", halt32, 1'b1);
      chk("prog1_no_ireq", ireq, 1'b0);

      clear_imem();
      imem[0] = 32'h2001_0005;
      imem[1] = 32'hAC01_0008;
      imem[2] = 32'h8C04_0008;
      ddelay = 3;
      restart();
      repeat (20) tick();
      chk("mem_not_halted_20", halt32, 1'b0);
      tick();
      chk("mem_halted_21", halt32, 1'b1);
      chk("mem_ntx", ntx, 2);
      chk("sw_req_cycles", dlen[0], 4);
      chk("lw_req_cycles", dlen[1], 4);
      chk("sw_addr", st_addr, 32'h8);
      chk("sw_data", st_data, 32'h5);
      chk("lw_r4", dut32.u_regfile.regs_q[4], 32'h5);
      chk("mem_pc", pc32, 32'hC);

      clear_imem();
      imem[0] = 32'h2001_0005;
      imem[1] = 32'h0021_303F;
      imem[2] = UNK_OP;
      imem[3] = UNK_OP;
      imem[4] = 32'h1021_0002;
      ddelay = 0;
      inoise = 1'b1;
      dnoise = 1'b1;
      restart();
      for (int i = 0; i < 60 && !halt32; i++) tick();
      chk("beq_halted", halt32, 1'b1);
      chk("beq_fetch_count", nf, 6);
      chk("beq_fetch4", flog[4], 32'h10);
      chk("beq_fetch5", flog[5], 32'h1C);
      chk("beq_pc", pc32, 32'h1C);
      chk("nop_no_dmem", ntx, 0);
      chk("nop_r5", dut32.u_regfile.regs_q[5], 32'h0);
      chk("nop_r6", dut32.u_regfile.regs_q[6], 32'h0);
      inoise = 1'b0;
      dnoise = 1'b0;

      clear_imem();
      imem[0] = 32'h2000_0007;
      imem[1] = 32'h0000_2820;
      imem[2] = 32'h2001_0005;
      imem[3] = UNK_OP;
      imem[4] = 32'h1421_0002;
      restart();
      for (int i = 0; i < 60 && !halt32; i++) tick();
      chk("bne_halted", halt32, 1'b1);
      chk("bne_fetch5", flog[5], 32'h14);
      chk("bne_pc", pc32, 32'h14);
      chk("r0_zero", dut32.u_regfile.regs_q[0], 32'h0);
      chk("r5_from_r0", dut32.u_regfile.regs_q[5], 32'h0);

      clear_imem();
      imem[0] = 32'h2001_0005;
      imem[1] = 32'h3408_F0F0;
      imem[2] = 32'h0101_4825;
      imem[3] = 32'h0109_5024;
      imem[4] = 32'h0028_5822;
      imem[5] = 32'h0161_602A;
      imem[6] = 32'h0800_0010;
      restart();
      repeat (28) tick();
      chk("alu_not_halted_28", halt32, 1'b0);
      tick();
      chk("alu_halted_29", halt32, 1'b1);
      chk("ori_r8", dut32.u_regfile.regs_q[8], 32'h0000_F0F0);
      chk("or_r9", dut32.u_regfile.regs_q[9], 32'h0000_F0F5);
      chk("and_r10", dut32.u_regfile.regs_q[10], 32'h0000_F0F0);
      chk("sub_r11", dut32.u_regfile.regs_q[11], 32'hFFFF_0F15);
      chk("slt_r12", dut32.u_regfile.regs_q[12], 32'h1);
      chk("j_pc", pc32, 32'h40);

      clear_imem();
      imem[0] = 32'h2001_0005;
      imem[1] = 32'h8C07_0000;
      dmem[0] = 32'h99;
      ddelay = 3;
      restart();
      for (int i = 0; i < 20 && !dreq; i++) tick();
      chk("abort_req_seen", dreq, 1'b1);
      rst32 = 1'b1;
      #1;
      chk("abort_rst_dreq", dreq, 1'b0);
      tick();
      rst32 = 1'b0;
      dnoise = 1'b1;
      nf = 0;
      #1;
      chk("abort_state", st32, 3'd0);
      chk("abort_pc", pc32, 32'h0);
      chk("abort_ir", dut32.ir_q, 32'h0);
      chk("abort_r1", dut32.u_regfile.regs_q[1], 32'h0);
      tick();
      dnoise = 1'b0;
      chk("abort_refetch", flog[0], 32'h0);
      chk("abort_decode", st32, 3'd1);
      chk("abort_r7", dut32.u_regfile.regs_q[7], 32'h0);
      repeat (13) tick();
      chk("abort_rerun_halt", halt32, 1'b1);
      chk("abort_rerun_r7", dut32.u_regfile.regs_q[7], 32'h99);

      imem64[0] = 32'h8C01_0000;
      imem64[1] = 32'h0001_1100;
      imem64[2] = 32'h0020_182A;
      imem64[3] = 32'h200C_FFFF;
      tick();
      rst64 = 1'b0;
      repeat (18) tick();
      chk("x64_not_halted_18", halt64, 1'b0);
      tick();
      chk("x64_halted_19", halt64, 1'b1);
      chk("x64_r1", dut64.u_regfile.regs_q[1], 64'hF000_0000_0000_0001);
      chk("x64_sll_r2", dut64.u_regfile.regs_q[2], 64'h10);
      chk("x64_slt_r3", dut64.u_regfile.regs_q[3], 64'h1);
      chk("x64_wrap_r4", dut64.u_regfile.regs_q[4], 64'hFFFF_FFFF_FFFF_FFFF);
      chk("x64_pc", pc64, 64'h10);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
